// File: rtl/conv_window_addr_gen.sv
// Walks a KxK stride-1 window across an IMG_W x IMG_W feature map, emitting one
// buffer read address per valid/ready handshake plus a per-frame ping-pong bank select.
module conv_window_addr_gen #(
    parameter int IMG_W = 5,
    parameter int K     = 3,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [AW-1:0] addr,
    output logic          bank_sel,
    output logic          tap_last,
    output logic          frame_last,
    output logic          busy,
    output logic          done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] KMAX = CW'(K - 1);
    localparam logic [CW-1:0] OMAX = CW'(IMG_W - K);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] kx_q, ky_q, ox_q, oy_q;
    logic [CW-1:0] kx_d, ky_d, ox_d, oy_d;

    logic          out_valid_d;
    logic [AW-1:0] addr_d;
    logic          bank_sel_d;
    logic          tap_last_d;
    logic          frame_last_d;
    logic          busy_d;
    logic          done_d;

    logic          handshake;
    logic          load;
    logic          advance;

    logic [AW:0]   row_w;
    logic [AW:0]   col_w;
    logic [AW:0]   addr_w;
    logic          tap_w;
    logic          frame_w;

    assign handshake = out_valid & out_ready;
    assign load      = (state_q == S_IDLE) && start;
    assign advance   = (state_q == S_RUN) && handshake && !frame_last;

    // Window counters: kx fastest, then ky, ox, oy. They always hold the
    // position of the address currently presented on addr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (load) begin
            kx_d = '0;
            ky_d = '0;
            ox_d = '0;
            oy_d = '0;
        end else if (advance) begin
            if (kx_q == KMAX) begin
                kx_d = '0;
                if (ky_q == KMAX) begin
                    ky_d = '0;
                    if (ox_q == OMAX) begin
                        ox_d = '0;
                        oy_d = (oy_q == OMAX) ? '0 : oy_q + CW'(1);
                    end else begin
                        ox_d = ox_q + CW'(1);
                    end
                end else begin
                    ky_d = ky_q + CW'(1);
                end
            end else begin
                kx_d = kx_q + CW'(1);
            end
        end
    end

    // Address and flags for the next counter position; one bit of headroom
    // keeps the intermediate sums exact before truncation to AW.
    always_comb begin
        row_w   = (AW+1)'(oy_d) + (AW+1)'(ky_d);
        col_w   = (AW+1)'(ox_d) + (AW+1)'(kx_d);
        addr_w  = row_w * (AW+1)'(IMG_W) + col_w;
        tap_w   = (kx_d == KMAX) && (ky_d == KMAX);
        frame_w = tap_w && (ox_d == OMAX) && (oy_d == OMAX);
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid;
        addr_d       = addr;
        bank_sel_d   = bank_sel;
        tap_last_d   = tap_last;
        frame_last_d = frame_last;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RUN;
                    out_valid_d  = 1'b1;
                    addr_d       = addr_w[AW-1:0];
                    tap_last_d   = tap_w;
                    frame_last_d = frame_w;
                end
            end
            S_RUN: begin
                if (handshake) begin
                    if (frame_last) begin
                        state_d      = S_DONE;
                        out_valid_d  = 1'b0;
                        tap_last_d   = 1'b0;
                        frame_last_d = 1'b0;
                        done_d       = 1'b1;
                        bank_sel_d   = ~bank_sel;
                    end else begin
                        addr_d       = addr_w[AW-1:0];
                        tap_last_d   = tap_w;
                        frame_last_d = frame_w;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            out_valid  <= 1'b0;
            addr       <= '0;
            bank_sel   <= 1'b0;
            tap_last   <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            out_valid  <= out_valid_d;
            addr       <= addr_d;
            bank_sel   <= bank_sel_d;
            tap_last   <= tap_last_d;
            frame_last <= frame_last_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed bench for conv_window_addr_gen: default 5x5/3x3 instance plus a 4x4/2x2 instance.
module tb_conv_window_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, out_ready;
    logic       out_valid, bank_sel, tap_last, frame_last, busy, done;
    logic [4:0] addr;

    logic       start_b, ready_b;
    logic       valid_b, bank_b, tap_b, fl_b, busy_b, done_b;
    logic [4:0] addr_b;

    int checks   = 0;
    int failures = 0;

    int exp_addr[$];
    int exp_tap[$];
    int exp_fl[$];
    int got_addr[$];
    int got_tap[$];
    int got_fl[$];

    int first18[18] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 1, 2, 3, 6, 7, 8, 11, 12, 13};
    int last9[9]    = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int b_first[4]  = '{0, 1, 4, 5};
    int b_last[4]   = '{10, 11, 14, 15};

    always #5 clk = ~clk;

    conv_window_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .addr(addr), .bank_sel(bank_sel),
        .tap_last(tap_last), .frame_last(frame_last), .busy(busy), .done(done)
    );

    conv_window_addr_gen #(.IMG_W(4), .K(2), .AW(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .out_ready(ready_b),
        .out_valid(valid_b), .addr(addr_b), .bank_sel(bank_b),
        .tap_last(tap_b), .frame_last(fl_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference sequence built from the nested window loops.
    task automatic build_model(input int w, input int k);
        exp_addr.delete(); exp_tap.delete(); exp_fl.delete();
        for (int oy = 0; oy <= w - k; oy++)
            for (int ox = 0; ox <= w - k; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        exp_addr.push_back((oy + ky) * w + ox + kx);
                        exp_tap.push_back((kx == k - 1 && ky == k - 1) ? 1 : 0);
                        exp_fl.push_back((kx == k - 1 && ky == k - 1 &&
                                          ox == w - k && oy == w - k) ? 1 : 0);
                    end
    endtask

    // Runs one frame on the default instance; called and left at a negedge.
    task automatic run_frame(input bit bp, input int abort_at, input bit mid_start,
                             input bit done_start, input int bank_before);
        bit         stalled = 0;
        bit         fin = 0;
        bit         aborted = 0;
        int         h_addr = 0, h_tap = 0, h_fl = 0;
        got_addr.delete(); got_tap.delete(); got_fl.delete();

        start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("valid_after_start", int'(out_valid), 1);
        check("busy_in_run", int'(busy), 1);

        for (int c = 0; c < 1000 && !fin; c++) begin
            if (stalled) begin
                check("stall_addr", int'(addr), h_addr);
                check("stall_tap_last", int'(tap_last), h_tap);
                check("stall_frame_last", int'(frame_last), h_fl);
            end
            if (bp) out_ready = (c >= 10 && c < 15) ? 1'b0 : 1'($urandom_range(0, 1));
            else    out_ready = 1'b1;
            start = (mid_start && got_addr.size() >= 30 && got_addr.size() < 33) ? 1'b1 : 1'b0;
            if (abort_at >= 0 && got_addr.size() == abort_at) begin
                rst = 1'b1;
                out_ready = 1'b1;
                aborted = 1;
            end
            stalled = out_valid && !out_ready;
            h_addr = int'(addr); h_tap = int'(tap_last); h_fl = int'(frame_last);
            if (out_valid && out_ready && !aborted) begin
                got_addr.push_back(int'(addr));
                got_tap.push_back(int'(tap_last));
                got_fl.push_back(int'(frame_last));
                if (frame_last) fin = 1;
            end
            @(negedge clk);
            if (aborted) fin = 1;
        end
        start = 1'b0;

        if (!fin) begin
            check("frame_timeout", 0, 1);
            return;
        end

        if (aborted) begin
            rst = 1'b0;
            check("abort_handshakes", got_addr.size(), abort_at);
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_addr", int'(addr), 0);
            check("abort_bank_sel", int'(bank_sel), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            return;
        end

        check("done_pulse", int'(done), 1);
        check("done_out_valid", int'(out_valid), 0);
        check("done_bank_sel", int'(bank_sel), 1 - bank_before);
        check("done_busy", int'(busy), 1);
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_out_valid", int'(out_valid), 0);

        check("frame_count", got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("addr[%0d]", i), got_addr[i], exp_addr[i]);
            check($sformatf("tap_last[%0d]", i), got_tap[i], exp_tap[i]);
            check($sformatf("frame_last[%0d]", i), got_fl[i], exp_fl[i]);
        end
    endtask

    initial begin
        int n;
        bit fin_b;
        rst = 1'b1; start = 1'b1; out_ready = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_bank_sel", int'(bank_sel), 0);
        check("rst_tap_last", int'(tap_last), 0);
        check("rst_frame_last", int'(frame_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_no_valid", int'(out_valid), 0);

        build_model(5, 3);
        check("model_len", exp_addr.size(), 81);

        // Unstalled frame, bank 0 -> 1, hand-computed window contents.
        run_frame(0, -1, 0, 0, 0);
        for (int i = 0; i < 18 && i < got_addr.size(); i++)
            check($sformatf("first18[%0d]", i), got_addr[i], first18[i]);
        n = got_addr.size();
        for (int i = 0; i < 9 && n >= 9; i++)
            check($sformatf("last9[%0d]", i), got_addr[n - 9 + i], last9[i]);
        if (n >= 9) check("frame_last_on_24", got_fl[n - 1] * 100 + got_addr[n - 1], 124);

        // Reset at handshake 40 while bank_sel is 1.
        run_frame(0, 40, 0, 0, 1);
        // Restart after reset: full frame from addr 0, bank 0 -> 1.
        run_frame(0, -1, 0, 0, 0);
        // Backpressure plus starts mid-frame and in DONE, bank 1 -> 0.
        run_frame(1, -1, 1, 1, 1);

        // Parameter sweep instance: IMG_W=4, K=2.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        got_addr.delete(); fin_b = 0;
        for (int c = 0; c < 200 && !fin_b; c++) begin
            if (valid_b) begin
                got_addr.push_back(int'(addr_b));
                if (fl_b) fin_b = 1;
            end
            @(negedge clk);
        end
        if (!fin_b) check("b_timeout", 0, 1);
        check("b_count", got_addr.size(), 36);
        check("b_done", int'(done_b), 1);
        check("b_bank_sel", int'(bank_b), 1);
        n = got_addr.size();
        for (int i = 0; i < 4 && n >= 4; i++) begin
            check($sformatf("b_first[%0d]", i), got_addr[i], b_first[i]);
            check($sformatf("b_last[%0d]", i), got_addr[n - 4 + i], b_last[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
